matrix_operand_fetch: RTL and testbench
=======================================

Name: matrix_operand_fetch

Overview:
Upstream stage of the coprocessor's 2x2 matrix adder. It reads two 2x2 single-precision matrices, A and B, from word-addressed operand memory, using a single-outstanding request/grant/response interface. It holds all eight words stable on parallel outputs and offers them to the adder with a valid/ready handshake. Sequencing is fixed: A00, A01, A10, A11, B00, B01, B10, B11.

Parameters:
ADDR_W, 16, width of memory word address and of base/stride inputs
DATA_W, 32, width of a matrix element (IEEE-754 single)
TIMEOUT_CYCLES, 255, response watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clock  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to fetch a matrix pair; sampled only in IDLE
base_a  in  ADDR_W  word address of A00
base_b  in  ADDR_W  word address of B00
row_stride  in  ADDR_W  word offset from element x0 to element x1 (row pitch)
busy  out  1  high in every state except IDLE
mem_req  out  1  read request, held until granted
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
a00,a01,a10,a11,b00,b01,b10,b11  out  DATA_W each  fetched operands, registered
op_valid  out  1  operand set complete and stable
op_ready  in  1  downstream accepts operand set
fetch_err  out  1  one-cycle pulse on watchdog abort (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, mem_req=0, mem_addr=0, op_valid=0, fetch_err=0, all eight operand registers=0, index=0. Reset mid-fetch aborts the fetch with no memory-side cleanup. The memory must drop any response still pending when reset occurs.
- States: IDLE, REQ, WAIT, PRESENT.
- IDLE:
  - On start=1, capture base_a, base_b and row_stride into internal registers; index=0; go to REQ.
  - start in any other state is ignored; it is neither queued nor captured.
- Address for index k (0..7): base = (k<4) ? base_a : base_b; offset by k mod 4 = {0, 1, stride, stride+1}.
  - Sum is modulo 2^ADDR_W; wrap-around is legal and silent.
- REQ:
  - mem_req=1 and mem_addr=address(index).
  - On mem_gnt=1, go to WAIT with mem_req=0 the next cycle.
  - There is no limit on the number of stall cycles.
- WAIT:
  - On mem_rvalid=1, write mem_rdata into the register for the current index.
  - If index==7, go to PRESENT; otherwise index+1 and go to REQ.
  - mem_rvalid in any state other than WAIT is ignored, including the same cycle as mem_gnt. The earliest usable response is therefore the cycle after the grant.
- PRESENT:
  - op_valid=1 and operands held stable.
  - On op_ready=1 the operand set is handed over; next state is IDLE, op_valid=0 the following cycle, and operand registers retain their values.
  - op_valid never drops without op_ready.
- Operand outputs change only on their own rvalid write, or on reset.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid on the next cycle):
  - start at cycle 0; requests issued at cycles 1, 3, …, 15; last data at cycle 16; op_valid=1 at cycle 17.
  - Each grant stall cycle or response stall cycle adds 1.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, go to IDLE, pulse fetch_err=1 for one cycle, leave op_valid=0, and keep the partially updated operand registers.
  - A response arriving on the limit cycle wins: data is taken and there is no error.
- Undefined: no counter; WAIT is held indefinitely and fetch_err is constant 0.

Test Plan:
1. Zero-wait memory, base_a=0x0010, base_b=0x0040, row_stride=4, memory[addr]=addr+0x3F800000:
   - Request addresses are 0x10, 0x11, 0x14, 0x15, 0x40, 0x41, 0x44, 0x45.
   - op_valid rises at cycle 17 with a00=0x3F800010 … b11=0x3F800045.
2. Grant stalled 3 cycles on request 0 and response stalled 2 cycles on request 5:
   - mem_addr is stable throughout the grant stall.
   - op_valid rises at cycle 22.
3. op_ready held 0 for 10 cycles in PRESENT, with start pulsed during the fetch and during PRESENT:
   - op_valid stays 1 with operands unchanged.
   - The start pulses are ignored, and IDLE is reached 1 cycle after op_ready=1.
4. base_a=0xFFFE, row_stride=1:
   - A addresses are 0xFFFE, 0xFFFF, 0xFFFF, 0x0000 (wrap).
   - Spurious mem_rvalid asserted in IDLE and in REQ changes no operand.
5. reset driven low in WAIT at index 5, then released, then a new start:
   - Outputs are immediately zero and state is IDLE.
   - The new fetch restarts at index 0 and completes correctly.
6. (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8) No response to request 2:
   - fetch_err pulses 8 cycles after WAIT entry; state returns to IDLE with op_valid=0 and busy=0.
   - With the response on exactly cycle 8, there is no error.

Source files
------------

// File: rtl/matrix_operand_fetch.sv
// rtl/matrix_operand_fetch.sv - fetches a 2x2 matrix pair for the matrix adder
//
// Purpose:
//   Reads A00, A01, A10, A11, B00, B01, B10, B11 from word-addressed operand
//   memory. The memory port allows one request in flight at a time. The eight
//   words are then held on parallel registered outputs and offered downstream
//   with a valid/ready handshake.
//
// Ports:
//   clock, reset           clock; asynchronous active-low reset
//   start_i                fetch request, sampled only while idle
//   base_a_i, base_b_i     word addresses of A00 and B00
//   row_stride_i           word offset from element x0 to element x1
//   busy_o                 high whenever not idle
//   mem_req_o, mem_addr_o  read request, held with a stable address until granted
//   mem_gnt_i              memory accepts the request
//   mem_rvalid_i           read data valid (only honoured while waiting)
//   mem_rdata_i            read data
//   a00_o .. b11_o         fetched operands, registered
//   op_valid_o, op_ready_i operand-set handshake
//   fetch_err_o            one-cycle pulse on response-watchdog abort
//
// Build option:
//   FETCH_TIMEOUT_EN       enables the response watchdog (TIMEOUT_CYCLES);
//                          without it WAIT holds forever and fetch_err_o is 0.
module matrix_operand_fetch #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_a_i,
   input  logic [ADDR_W-1:0] base_b_i,
   input  logic [ADDR_W-1:0] row_stride_i,
   output logic              busy_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] a00_o,
   output logic [DATA_W-1:0] a01_o,
   output logic [DATA_W-1:0] a10_o,
   output logic [DATA_W-1:0] a11_o,
   output logic [DATA_W-1:0] b00_o,
   output logic [DATA_W-1:0] b01_o,
   output logic [DATA_W-1:0] b10_o,
   output logic [DATA_W-1:0] b11_o,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   output logic              fetch_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, PRESENT} state_t;

   state_t            state_q;
   logic [2:0]        index_q;
   logic [ADDR_W-1:0] base_a_q;
   logic [ADDR_W-1:0] base_b_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_req_q;
   logic              busy_q;
   logic              op_valid_q;
   logic [DATA_W-1:0] opnd_q [8];
   logic [ADDR_W-1:0] addr_next_d;

   // Element k: bit 2 picks the matrix, bit 1 adds the row stride, bit 0 the column.
   // Sums wrap modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] elem_addr(input logic [2:0]        k,
                                                   input logic [ADDR_W-1:0] ba,
                                                   input logic [ADDR_W-1:0] bb,
                                                   input logic [ADDR_W-1:0] st);
      logic [ADDR_W-1:0] b_sel;
      logic [ADDR_W-1:0] r_off;
      b_sel = k[2] ? bb : ba;
      r_off = k[1] ? st : '0;
      return b_sel + r_off + ADDR_W'(k[0]);
   endfunction

   assign addr_next_d = elem_addr(index_q + 3'd1, base_a_q, base_b_q, stride_q);

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q;
   logic             fetch_err_q;
   assign fetch_err_o = fetch_err_q;
`else
   assign fetch_err_o = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         index_q    <= '0;
         base_a_q   <= '0;
         base_b_q   <= '0;
         stride_q   <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         op_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++) opnd_q[i] <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
`endif
      end else begin
`ifdef FETCH_TIMEOUT_EN
         fetch_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  base_a_q   <= base_a_i;
                  base_b_q   <= base_b_i;
                  stride_q   <= row_stride_i;
                  index_q    <= '0;
                  mem_addr_q <= base_a_i;
                  mem_req_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt_q <= '0;
`endif
               end
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  opnd_q[index_q] <= mem_rdata_i;
                  if (index_q == 3'd7) begin
                     op_valid_q <= 1'b1;
                     state_q    <= PRESENT;
                  end else begin
                     index_q    <= index_q + 3'd1;
                     mem_addr_q <= addr_next_d;
                     mem_req_q  <= 1'b1;
                     state_q    <= REQ;
                  end
               end
`ifdef FETCH_TIMEOUT_EN
               // A response on the limit cycle takes priority over the abort.
               else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  busy_q      <= 1'b0;
                  fetch_err_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
`endif
            end
            PRESENT: begin
               if (op_ready_i) begin
                  op_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = mem_addr_q;
   assign op_valid_o = op_valid_q;
   assign a00_o      = opnd_q[0];
   assign a01_o      = opnd_q[1];
   assign a10_o      = opnd_q[2];
   assign a11_o      = opnd_q[3];
   assign b00_o      = opnd_q[4];
   assign b01_o      = opnd_q[5];
   assign b10_o      = opnd_q[6];
   assign b11_o      = opnd_q[7];

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// tb/tb_matrix_operand_fetch.sv - scoreboard bench for matrix_operand_fetch
module tb_matrix_operand_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_a = '0, base_b = '0, row_stride = '0;
   logic        busy_o, mem_req_o, op_valid_o, fetch_err_o;
   logic [15:0] mem_addr_o;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, op_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11;

   matrix_operand_fetch #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .start_i(start),
      .base_a_i(base_a), .base_b_i(base_b), .row_stride_i(row_stride),
      .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .a00_o(a00), .a01_o(a01), .a10_o(a10), .a11_o(a11),
      .b00_o(b00), .b01_o(b01), .b10_o(b10), .b11_o(b11),
      .op_valid_o(op_valid_o), .op_ready_i(op_ready), .fetch_err_o(fetch_err_o));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0, bad = 0;

   // scenario knobs set by stimulus before each start
   logic [31:0] salt = '0;
   int  gstall[8], rstall[8];
   int  ready_delay = 0;
   bit  spurious = 0;

   // memory responder / monitor state
   int  req_idx = 0, gcnt = 0, rcnt = 0, rdy_cnt = 0;
   bit  resp_pending = 0, seen = 0, prev_hs = 0, prev_hold = 0;
   logic [15:0] resp_addr = '0;
   int  gnt_cyc[8];
   int  done_cnt = 0, err_cnt = 0, err_cyc = 0;
   logic [255:0] cur_w = '0;

   // scoreboard
   logic [15:0]  exp_addr[$];
   logic [255:0] exp_w[$];
   int           exp_lat[$];
   int           exp_start[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [15:0] a);
      return 32'h3F80_0000 + {16'h0, a} + salt;
   endfunction

   function automatic logic [15:0] ref_addr(input int k, input logic [15:0] ba,
                                            input logic [15:0] bb, input logic [15:0] st);
      int unsigned sum;
      sum = (k < 4) ? ba : bb;
      if ((k % 4) >= 2) sum += st;
      sum += (k % 2);
      return 16'(sum % 65536);
   endfunction

   function automatic logic [255:0] ops_now();
      return {b11, b10, b01, b00, a11, a10, a01, a00};
   endfunction

   // memory model, ready driver and output monitor
   initial begin
      for (int i = 0; i < 8; i++) begin gstall[i] = 0; rstall[i] = 0; gnt_cyc[i] = 0; end
      forever begin
         @(negedge clock);
         if (!reset) begin
            resp_pending = 0; req_idx = 0; gcnt = 0; rcnt = 0;
            mem_gnt = 0; mem_rvalid = 0; op_ready = 0;
            seen = 0; prev_hs = 0; prev_hold = 0;
         end else begin
            if (fetch_err_o) begin err_cnt++; err_cyc = cyc; resp_pending = 0; end
            if (prev_hs) begin
               chk("idle_after_ready", {busy_o, op_valid_o}, 2'b00);
               done_cnt++;
            end
            if (prev_hold) chk("valid_held", op_valid_o, 1'b1);
            if (op_valid_o && !seen) begin
               seen = 1;
               if (exp_w.size() == 0) chk("unexpected_set", 1, 0);
               else begin
                  cur_w = exp_w.pop_front();
                  chk("latency", cyc - exp_start.pop_front(), exp_lat.pop_front());
                  for (int k = 0; k < 8; k++) begin
                     logic [255:0] ow;
                     ow = ops_now();
                     chk($sformatf("operand%0d", k), ow[32*k +: 32], cur_w[32*k +: 32]);
                  end
               end
            end else if (op_valid_o) begin
               chk("ops_stable", ops_now(), cur_w);
            end
            if (!op_valid_o) seen = 0;

            if (op_valid_o) begin
               if (rdy_cnt > 0) begin op_ready = 0; rdy_cnt--; end
               else op_ready = 1;
            end else begin
               op_ready = 0; rdy_cnt = ready_delay;
            end
            prev_hs   = op_valid_o && op_ready;
            prev_hold = op_valid_o && !op_ready;

            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (resp_pending) begin
               if (rcnt < rstall[(req_idx + 7) % 8]) rcnt++;
               else begin
                  mem_rvalid = 1; mem_rdata = data_of(resp_addr); resp_pending = 0;
               end
            end else if (spurious && $urandom_range(0, 1) == 1) begin
               mem_rvalid = 1;
            end
            if (mem_req_o) begin
               if (exp_addr.size() == 0) chk("unexpected_req", 1, 0);
               else chk("req_addr", mem_addr_o, exp_addr[0]);
               if (gcnt < gstall[req_idx % 8]) gcnt++;
               else begin
                  mem_gnt = 1; gcnt = 0; rcnt = 0;
                  resp_addr = mem_addr_o;
                  if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                  gnt_cyc[req_idx % 8] = cyc;
                  req_idx++;
                  resp_pending = 1;
               end
            end
         end
      end
   end

   task automatic clear_stalls();
      for (int i = 0; i < 8; i++) begin gstall[i] = 0; rstall[i] = 0; end
   endtask

   task automatic issue(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] st,
                        input logic [31:0] s, input int n_req, input bit expect_set);
      logic [255:0] w;
      int lat;
      salt = s;
      req_idx = 0;
      for (int k = 0; k < n_req; k++) exp_addr.push_back(ref_addr(k, ba, bb, st));
      if (expect_set) begin
         lat = 17;
         for (int k = 0; k < 8; k++) begin
            w[32*k +: 32] = data_of(ref_addr(k, ba, bb, st));
            lat += gstall[k] + rstall[k];
         end
         exp_w.push_back(w); exp_lat.push_back(lat); exp_start.push_back(cyc);
      end
      base_a = ba; base_b = bb; row_stride = st; start = 1;
      @(negedge clock); #1;
      start = 0; base_a = 16'($urandom); base_b = 16'($urandom); row_stride = 16'($urandom);
   endtask

   task automatic run_fetch(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] st,
                            input logic [31:0] s, input int n_req, input bit expect_set,
                            input bit extra);
      int target;
      bit fin;
      target = done_cnt + 1;
      fin = 0;
      issue(ba, bb, st, s, n_req, expect_set);
      for (int c = 0; c < 3000; c++) begin
         if (expect_set ? (done_cnt >= target) : (busy_o == 1'b0)) begin fin = 1; break; end
         start = 0;
         if (extra && busy_o && $urandom_range(0, 3) == 0) begin
            start = 1; base_a = 16'($urandom); base_b = 16'($urandom);
            row_stride = 16'($urandom);
         end
         @(negedge clock); #1;
      end
      start = 0;
      if (!fin) chk("fetch_finished", 0, 1);
   endtask

   int exp_err = 0;

   initial begin
      @(negedge clock); #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_valid", op_valid_o, 0);
      chk("rst_err", fetch_err_o, 0);
      chk("rst_ops", ops_now(), 256'h0);
      @(negedge clock); #1; reset = 1;
      @(negedge clock); #1;

      // zero-wait memory, directed bases
      clear_stalls(); ready_delay = 0; spurious = 0;
      run_fetch(16'h0010, 16'h0040, 16'h0004, 32'h0, 8, 1, 0);
      chk("t1_a00", a00, 32'h3F80_0010);
      chk("t1_b11", b11, 32'h3F80_0045);

      // grant stall on request 0, response stall on request 5
      clear_stalls(); gstall[0] = 3; rstall[5] = 2;
      run_fetch(16'h0100, 16'h0200, 16'h0010, 32'h1234, 8, 1, 0);

      // downstream back-pressure with start pulses during fetch and present
      clear_stalls(); ready_delay = 10;
      run_fetch(16'h0300, 16'h0400, 16'h0020, 32'h55AA, 8, 1, 1);

      // address wrap with spurious responses outside WAIT
      clear_stalls(); ready_delay = 1; spurious = 1; gstall[1] = 2; gstall[3] = 1;
      run_fetch(16'hFFFE, 16'hFFF0, 16'h0001, 32'h0BAD, 8, 1, 0);
      spurious = 0;

      // reset while waiting on request 5
      clear_stalls(); rstall[5] = 3; ready_delay = 0;
      issue(16'h0500, 16'h0600, 16'h0008, 32'h7777, 8, 1);
      begin
         bit hit;
         hit = 0;
         for (int c = 0; c < 200; c++) begin
            if (req_idx == 6 && resp_pending && !mem_req_o) begin hit = 1; break; end
            @(negedge clock); #1;
         end
         if (!hit) chk("reach_wait5", 0, 1);
      end
      reset = 0;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_req", mem_req_o, 0);
      chk("mid_rst_addr", mem_addr_o, 0);
      chk("mid_rst_valid", op_valid_o, 0);
      chk("mid_rst_ops", ops_now(), 256'h0);
      exp_addr.delete(); exp_w.delete(); exp_lat.delete(); exp_start.delete();
      @(negedge clock); #1; reset = 1;
      @(negedge clock); #1;
      clear_stalls();
      run_fetch(16'h0700, 16'h0800, 16'h0002, 32'h9999, 8, 1, 0);

`ifdef FETCH_TIMEOUT_EN
      // no response to request 2: watchdog abort
      clear_stalls(); rstall[2] = 1000;
      run_fetch(16'h0900, 16'h0A00, 16'h0004, 32'h4444, 3, 0, 0);
      exp_err = 1;
      chk("to_err_count", err_cnt, 1);
      chk("to_err_timing", err_cyc - gnt_cyc[2], 9);
      chk("to_valid", op_valid_o, 0);
      chk("to_busy", busy_o, 0);
      // response on the limit cycle wins
      clear_stalls(); rstall[2] = 7;
      run_fetch(16'h0B00, 16'h0C00, 16'h0004, 32'h4545, 8, 1, 0);
`endif

      // randomized traffic
      for (int t = 0; t < 15; t++) begin
         for (int i = 0; i < 8; i++) begin
            gstall[i] = $urandom_range(0, 3); rstall[i] = $urandom_range(0, 3);
         end
         ready_delay = $urandom_range(0, 4);
         spurious = ($urandom_range(0, 1) == 1);
         run_fetch(16'($urandom), 16'($urandom), 16'($urandom), $urandom, 8, 1,
                   ($urandom_range(0, 1) == 1));
      end
      spurious = 0;

      chk("fetch_err_count", err_cnt, exp_err);
      chk("leftover_sets", exp_w.size(), 0);
      chk("leftover_addrs", exp_addr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
